// File: rtl/btb_nway.sv
// -----------------------------------------------------------------------------
// btb_nway -- N-way set-associative branch target buffer
//
// Purpose:
//   Holds predicted targets for branches. The fetch stage looks up a PC
//   combinationally and gets hit / target / taken-prediction. The execute
//   stage writes back each resolved branch:
//     - on a hit, the entry's 2-bit counter is trained and it is touched;
//     - on a taken miss, a new entry is allocated;
//     - on a not-taken miss, nothing changes.
//   Replacement is true LRU, tracked by a per-way age
//   (0 = most recent, WAYS-1 = least recent).
//
// Parameters:
//   SETS  number of sets (power of 2, >= 2)
//   WAYS  associativity  (power of 2, 2..8)
//   XLEN  PC / target width
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   lookup_pc      fetch PC to look up
//   lookup_hit     a valid entry matches lookup_pc
//   lookup_target  stored target on hit, else 0
//   lookup_taken   counter MSB of the hit entry, else 0
//   update_en      a resolved branch is presented this cycle
//   update_pc      PC of the resolved branch
//   update_target  resolved target address
//   update_taken   actual branch outcome
//   flush          invalidate every entry (dominates a same-cycle update)
//
// Optional feature:
//   BTB_BYPASS_EN  when defined, a same-cycle update to the looked-up entry is
//                  forwarded to the lookup outputs.
// -----------------------------------------------------------------------------
module btb_nway #(
    parameter int SETS = 8,
    parameter int WAYS = 2,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_hit,
    output logic [XLEN-1:0] lookup_target,
    output logic            lookup_taken,
    input  logic            update_en,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken,
    input  logic            flush
);
    localparam int IDX_W = $clog2(SETS);
    localparam int AGE_W = $clog2(WAYS);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    // Entry storage
    logic             valid_q  [SETS][WAYS];
    logic [TAG_W-1:0] tag_q    [SETS][WAYS];
    logic [XLEN-1:0]  target_q [SETS][WAYS];
    logic [1:0]       ctr_q    [SETS][WAYS];
    logic [AGE_W-1:0] age_q    [SETS][WAYS];

    // Address split; pc[1:0] never participates
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] up_tag;
    logic             unused_pc_lsbs;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[XLEN-1:IDX_W+2];
    assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

    // Per-way tag compare for both ports
    logic [WAYS-1:0] lk_match;
    logic [WAYS-1:0] up_match;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
            assign lk_match[gi] = valid_q[lk_idx][gi] && (tag_q[lk_idx][gi] == lk_tag);
            assign up_match[gi] = valid_q[up_idx][gi] && (tag_q[up_idx][gi] == up_tag);
        end
    endgenerate

    // Hit / victim selection.
    // The loops scan downwards so that the lowest matching index wins.
    logic             lk_hit;
    logic [AGE_W-1:0] lk_way;
    logic             up_hit;
    logic [AGE_W-1:0] up_way;
    logic             has_invalid;
    logic [AGE_W-1:0] inv_way;
    logic [AGE_W-1:0] lru_way;

    always_comb begin
        lk_hit      = 1'b0;
        lk_way      = '0;
        up_hit      = 1'b0;
        up_way      = '0;
        has_invalid = 1'b0;
        inv_way     = '0;
        lru_way     = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lk_match[w]) begin
                lk_hit = 1'b1;
                lk_way = AGE_W'(w);
            end
            if (up_match[w]) begin
                up_hit = 1'b1;
                up_way = AGE_W'(w);
            end
            if (!valid_q[up_idx][w]) begin
                has_invalid = 1'b1;
                inv_way     = AGE_W'(w);
            end
            if (age_q[up_idx][w] == AGE_W'(WAYS - 1)) begin
                lru_way = AGE_W'(w);
            end
        end
    end

    // Next-state for the one set addressed by the update port
    logic             up_write;
    logic [AGE_W-1:0] touch_way;
    logic [AGE_W-1:0] touch_age;
    logic [1:0]       ctr_old;
    logic [1:0]       ctr_d;
    logic [XLEN-1:0]  target_d;
    logic [AGE_W-1:0] age_d [WAYS];

    always_comb begin
        // A not-taken miss leaves the set completely untouched
        up_write  = update_en && (up_hit || update_taken);
        touch_way = up_hit ? up_way : (has_invalid ? inv_way : lru_way);
        touch_age = age_q[up_idx][touch_way];
        ctr_old   = ctr_q[up_idx][touch_way];

        if (up_hit) begin
            if (update_taken) begin
                ctr_d = (ctr_old == 2'b11) ? 2'b11 : ctr_old + 2'b01;
            end else begin
                ctr_d = (ctr_old == 2'b00) ? 2'b00 : ctr_old - 2'b01;
            end
        end else begin
            ctr_d = 2'b10;  // fresh allocations start weakly taken
        end

        // Target only refreshes on a taken outcome (or a new allocation)
        target_d = (!up_hit || update_taken) ? update_target : target_q[up_idx][touch_way];

        // True LRU: ways younger than the touched one age by one
        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == touch_way) begin
                age_d[w] = '0;
            end else if (age_q[up_idx][w] < touch_age) begin
                age_d[w] = age_q[up_idx][w] + AGE_W'(1);
            end else begin
                age_d[w] = age_q[up_idx][w];
            end
        end
    end

    // State update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w]  <= 1'b0;
                    tag_q[s][w]    <= '0;
                    target_q[s][w] <= '0;
                    ctr_q[s][w]    <= 2'b00;
                    age_q[s][w]    <= AGE_W'(w);
                end
            end
        end else if (flush) begin
            // Tags and targets are left stale; valid=0 hides them
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    ctr_q[s][w]   <= 2'b00;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
        end else if (up_write) begin
            for (int w = 0; w < WAYS; w++) begin
                age_q[up_idx][w] <= age_d[w];
            end
            valid_q[up_idx][touch_way]  <= 1'b1;
            tag_q[up_idx][touch_way]    <= up_tag;
            target_q[up_idx][touch_way] <= target_d;
            ctr_q[up_idx][touch_way]    <= ctr_d;
        end
    end

    // Lookup outputs (combinational, zero latency)
    always_comb begin
        lookup_hit    = lk_hit;
        lookup_target = lk_hit ? target_q[lk_idx][lk_way] : '0;
        lookup_taken  = lk_hit ? ctr_q[lk_idx][lk_way][1] : 1'b0;
`ifdef BTB_BYPASS_EN
        if (update_en && !flush && (lk_idx == up_idx) && (lk_tag == up_tag)) begin
            if (update_taken) begin
                lookup_hit    = 1'b1;
                lookup_target = update_target;
                lookup_taken  = ctr_d[1];
            end else if (lk_hit) begin
                // Same entry, so the update port hits the same way
                lookup_taken = ctr_d[1];
            end
        end
`endif
    end

endmodule

// File: doc/btb_nway.md
Name: btb_nway

Overview:
- Parametrised N-way set-associative branch target buffer: storage, lookup and update in one block.
- The IF stage looks up the fetch PC combinationally and gets hit, predicted target and taken prediction.
- The EX stage writes back each resolved branch: allocation, target refresh, 2-bit counter training and true-LRU replacement.
- Generalises the fixed 8-set/2-way BTB update path to configurable sets and ways, adds owned storage, a flush, and outcome-based training.

Parameters:
- SETS, 8, number of sets; power of 2, >=2; IDX_W = log2(SETS).
- WAYS, 2, associativity; power of 2, 2..8; AGE_W = log2(WAYS).
- XLEN, 32, PC/target width; TAG_W = XLEN-2-IDX_W (27 at defaults).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- lookup_pc  in  XLEN  IF-stage fetch PC.
- lookup_hit  out  1  a valid entry matches lookup_pc.
- lookup_target  out  XLEN  stored target on hit, else 0.
- lookup_taken  out  1  counter[1] of the hit entry, else 0.
- update_en  in  1  a resolved branch is presented this cycle.
- update_pc  in  XLEN  PC of the resolved branch.
- update_target  in  XLEN  resolved target address.
- update_taken  in  1  actual branch outcome.
- flush  in  1  invalidate all entries (e.g. fence.i).

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[XLEN-1:IDX_W+2]
  - pc[1:0] ignored.
- Per-way entry: valid, tag[TAG_W], target[XLEN], ctr[2], age[AGE_W].
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Reset (async) and flush (sync):
  - all valid=0, ctr=00, age of way w = w in every set.
  - Outputs reset to 0, since no entry is valid.
  - flush has priority over a same-cycle update_en; the update is dropped.
- Lookup: purely combinational, zero latency.
  - Hit way = lowest-index way that is valid with a matching tag.
  - Multiple matches cannot occur by construction.
- Update, registered at the clk edge when update_en=1 and flush=0:
  - Hit, any outcome:
    - ctr saturating +1 if taken, -1 if not taken (11 stays 11, 00 stays 00).
    - target := update_target only if taken.
    - Way is touched in LRU.
  - Miss and taken: allocate.
    - Victim = lowest-index invalid way; if none, the way with age = WAYS-1.
    - Write valid=1, tag, target, ctr=10 (WT); victim is touched.
  - Miss and not taken: no state change, no allocation, LRU untouched.
- LRU update (true LRU by age):
  - Touching way w with age a: every way in the set with age < a increments; w gets age 0.
  - Ages in a set always remain a permutation of 0..WAYS-1.
- Lookup does not touch LRU.
- Same-cycle lookup and update to the same set: lookup sees pre-update contents unless BTB_BYPASS_EN is defined.
- Different sets are fully independent; only the addressed set changes on an update.
- Update pointing at its own PC (target==pc) is stored as-is; there is no special case.

Optional Feature:
- Macro: BTB_BYPASS_EN.
- Defined:
  - If update_en=1, flush=0, update_taken=1 and the update tag/index equal the lookup tag/index, lookup_hit=1, lookup_target=update_target, and lookup_taken=counter[1] of the post-update value in the same cycle.
  - A not-taken same-entry update forwards the post-update counter[1] only if the entry already hits.
- Undefined: no forwarding; the new contents become visible the cycle after the edge.

Test Plan:
- Reset, then lookup_pc=0x0000_1000 -> lookup_hit=0, lookup_target=0, lookup_taken=0.
- Update pc=0x1000, target=0x2000, taken=1; next cycle lookup 0x1000 -> hit=1, target=0x2000, taken=1 (ctr=10). Two not-taken updates -> ctr 01 then 00, lookup_taken=0. Three taken updates -> ctr saturates at 11.
- Defaults (SETS=8, WAYS=2): allocate 0x1000 and 0x1020 (same index 0), update 0x1000 again, then allocate 0x1040 -> 0x1020 is evicted, 0x1000 and 0x1040 hit.
- Miss update pc=0x3000, taken=0 -> next-cycle lookup 0x3000 hit=0; LRU ages of set 0 unchanged.
- Fill several sets, then assert flush together with update_en for pc=0x1000 -> all lookups miss next cycle, the update is not written; assert rst mid-run asynchronously -> outputs 0 immediately.
- Same-cycle update 0x5000/0x6000 taken while looking up 0x5000 -> hit=0 without BTB_BYPASS_EN; hit=1, target=0x6000 with it.
